// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / RAW hazard detection.
// Inserts bubbles on taken branches and on hazards, holds operand data
// across bubbles, and counts hazard bubble cycles with saturation.
module id_ex_stage #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [2:0]    id_src1,
    input  logic [2:0]    id_src2,
    input  logic [2:0]    id_dest,
    input  logic          id_use_src2,
    input  logic [DW-1:0] id_val1,
    input  logic [DW-1:0] id_val2,
    input  logic [DW-1:0] id_imm,
    input  logic [3:0]    id_alu_cmd,
    input  logic          id_wb_en,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic [2:0]    mem_dest,
    input  logic          mem_wb_en,
    input  logic          branch_taken,
    input  logic          forwarding_en,
    output logic          ex_valid,
    output logic          ex_wb_en,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic [2:0]    ex_src1,
    output logic [2:0]    ex_src2,
    output logic [2:0]    ex_dest,
    output logic [DW-1:0] ex_val1,
    output logic [DW-1:0] ex_val2,
    output logic [DW-1:0] ex_imm,
    output logic [3:0]    ex_alu_cmd,
    output logic          hazard_stall,
    output logic [15:0]   stall_count
);

    localparam logic [2:0]  REG_ZERO = 3'd0;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // A source conflicts with a producer only when the producer writes, the
    // addresses match, and the source is not r0 (r0 is never written).
    function automatic logic src_conflict(input logic [2:0] src,
                                          input logic [2:0] dst,
                                          input logic       wr);
        src_conflict = wr & (src != REG_ZERO) & (src == dst);
    endfunction

    logic          ex_valid_r;
    logic          ex_wb_en_r;
    logic          ex_mem_read_r;
    logic          ex_mem_write_r;
    logic [2:0]    ex_src1_r;
    logic [2:0]    ex_src2_r;
    logic [2:0]    ex_dest_r;
    logic [DW-1:0] ex_val1_r;
    logic [DW-1:0] ex_val2_r;
    logic [DW-1:0] ex_imm_r;
    logic [3:0]    ex_alu_cmd_r;
    logic [15:0]   stall_count_r;

    logic          ex_load_s;
    logic          ex_writer_s;
    logic          hazard_fwd_s;
    logic          hazard_nofwd_s;
    logic          hazard_s;
    logic          hazard_stall_s;

    // Hazard detection: with forwarding only a load in EX must wait; without
    // it any pending write in EX or MEM blocks the reader (WB writes first).
    always_comb begin
        ex_load_s      = ex_valid_r & ex_mem_read_r;
        ex_writer_s    = ex_valid_r & ex_wb_en_r;
        hazard_fwd_s   = 1'b0;
        hazard_nofwd_s = 1'b0;
        hazard_s       = 1'b0;
        hazard_stall_s = 1'b0;

        if (id_valid) begin
            hazard_fwd_s = src_conflict(id_src1, ex_dest_r, ex_load_s) |
                           (id_use_src2 & src_conflict(id_src2, ex_dest_r, ex_load_s));
            hazard_nofwd_s = src_conflict(id_src1, ex_dest_r, ex_writer_s) |
                             src_conflict(id_src1, mem_dest, mem_wb_en)     |
                             (id_use_src2 &
                              (src_conflict(id_src2, ex_dest_r, ex_writer_s) |
                               src_conflict(id_src2, mem_dest, mem_wb_en)));
        end else begin
            hazard_fwd_s   = 1'b0;
            hazard_nofwd_s = 1'b0;
        end

        if (forwarding_en) begin
            hazard_s = hazard_fwd_s;
        end else begin
            hazard_s = hazard_nofwd_s;
        end

        hazard_stall_s = hazard_s & ~branch_taken;
    end

    // Pipeline register: reset, then branch bubble, then hazard bubble, else
    // load ID. Bubbles clear control/addresses but keep the data fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_r     <= 1'b0;
            ex_wb_en_r     <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_mem_write_r <= 1'b0;
            ex_src1_r      <= REG_ZERO;
            ex_src2_r      <= REG_ZERO;
            ex_dest_r      <= REG_ZERO;
            ex_val1_r      <= {DW{1'b0}};
            ex_val2_r      <= {DW{1'b0}};
            ex_imm_r       <= {DW{1'b0}};
            ex_alu_cmd_r   <= 4'd0;
        end else if (branch_taken || hazard_s) begin
            ex_valid_r     <= 1'b0;
            ex_wb_en_r     <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_mem_write_r <= 1'b0;
            ex_src1_r      <= REG_ZERO;
            ex_src2_r      <= REG_ZERO;
            ex_dest_r      <= REG_ZERO;
        end else begin
            ex_valid_r     <= id_valid;
            ex_wb_en_r     <= id_valid & id_wb_en;
            ex_mem_read_r  <= id_valid & id_mem_read;
            ex_mem_write_r <= id_valid & id_mem_write;
            ex_src1_r      <= id_src1;
            ex_src2_r      <= id_src2;
            ex_dest_r      <= id_dest;
            ex_val1_r      <= id_val1;
            ex_val2_r      <= id_val2;
            ex_imm_r       <= id_imm;
            ex_alu_cmd_r   <= id_alu_cmd;
        end
    end

    // Hazard bubble counter, saturating; branch-squashed cycles are not hazards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_r <= 16'd0;
        end else if (hazard_stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign ex_valid     = ex_valid_r;
    assign ex_wb_en     = ex_wb_en_r;
    assign ex_mem_read  = ex_mem_read_r;
    assign ex_mem_write = ex_mem_write_r;
    assign ex_src1      = ex_src1_r;
    assign ex_src2      = ex_src2_r;
    assign ex_dest      = ex_dest_r;
    assign ex_val1      = ex_val1_r;
    assign ex_val2      = ex_val2_r;
    assign ex_imm       = ex_imm_r;
    assign ex_alu_cmd   = ex_alu_cmd_r;
    assign hazard_stall = hazard_stall_s;
    assign stall_count  = stall_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_src1, id_src2, id_dest;
    logic        id_use_src2;
    logic [15:0] id_val1, id_val2, id_imm;
    logic [3:0]  id_alu_cmd;
    logic        id_wb_en, id_mem_read, id_mem_write;
    logic [2:0]  mem_dest;
    logic        mem_wb_en;
    logic        branch_taken;
    logic        forwarding_en;
    logic        ex_valid, ex_wb_en, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_src1, ex_src2, ex_dest;
    logic [15:0] ex_val1, ex_val2, ex_imm;
    logic [3:0]  ex_alu_cmd;
    logic        hazard_stall;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
        .id_use_src2(id_use_src2), .id_val1(id_val1), .id_val2(id_val2),
        .id_imm(id_imm), .id_alu_cmd(id_alu_cmd), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .forwarding_en(forwarding_en), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
        .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_imm(ex_imm),
        .ex_alu_cmd(ex_alu_cmd), .hazard_stall(hazard_stall),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                            input logic [2:0] d, input logic u2, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] im, input logic [3:0] cmd,
                            input logic wb, input logic mr, input logic mw);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_dest = d; id_use_src2 = u2;
        id_val1 = a; id_val2 = b; id_imm = im; id_alu_cmd = cmd;
        id_wb_en = wb; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic idle_inputs();
        drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        mem_dest = 3'd0; mem_wb_en = 1'b0; branch_taken = 1'b0; forwarding_en = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        // valid instruction and branch present during reset must not load
        drive_id(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 4'h5, 1'b1, 1'b1, 1'b1);
        branch_taken = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid got %0h exp 0", ex_valid); end
        checks++; if (ex_dest !== 3'd0) begin errors++; $display("FAIL rst_ex_dest got %0h exp 0", ex_dest); end
        checks++; if (ex_val1 !== 16'h0) begin errors++; $display("FAIL rst_ex_val1 got %0h exp 0", ex_val1); end
        checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL rst_stall_count got %0h exp 0", stall_count); end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_hazard_stall got %0h exp 0", hazard_stall); end
        branch_taken = 1'b0;
        rst_n = 1'b1;
        tick();
        // first edge with rst_n=1 performs a normal load
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rst_first_load_valid got %0h exp 1", ex_valid); end
        checks++; if (ex_imm !== 16'hCCCC) begin errors++; $display("FAIL rst_first_load_imm got %0h exp cccc", ex_imm); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        forwarding_en = 1'b1;
        drive_id(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 16'h1234, 16'h5678, 16'h9ABC, 4'h7, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if ({ex_valid, ex_wb_en, ex_mem_read, ex_mem_write} !== 4'b1101) begin errors++; $display("FAIL b2b_ctrl1 got %b exp 1101", {ex_valid, ex_wb_en, ex_mem_read, ex_mem_write}); end
        checks++; if ({ex_src1, ex_src2, ex_dest} !== {3'd1, 3'd2, 3'd3}) begin errors++; $display("FAIL b2b_addr1 got %0h %0h %0h exp 1 2 3", ex_src1, ex_src2, ex_dest); end
        checks++; if ({ex_val1, ex_val2, ex_imm, ex_alu_cmd} !== {16'h1234, 16'h5678, 16'h9ABC, 4'h7}) begin errors++; $display("FAIL b2b_data1 got %0h %0h %0h %0h", ex_val1, ex_val2, ex_imm, ex_alu_cmd); end
        drive_id(1'b1, 3'd4, 3'd5, 3'd6, 1'b1, 16'h0F0F, 16'hF0F0, 16'h0001, 4'h2, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if ({ex_valid, ex_wb_en, ex_dest, ex_val2, ex_alu_cmd} !== {1'b1, 1'b0, 3'd6, 16'hF0F0, 4'h2}) begin errors++; $display("FAIL b2b_load2 got %0h %0h %0h %0h %0h", ex_valid, ex_wb_en, ex_dest, ex_val2, ex_alu_cmd); end
        // invalid ID: control bits gated, addresses/data still load
        drive_id(1'b0, 3'd5, 3'd1, 3'd7, 1'b1, 16'h2222, 16'h3333, 16'h4444, 4'h9, 1'b1, 1'b1, 1'b1);
        tick();
        checks++; if ({ex_valid, ex_wb_en, ex_mem_read, ex_mem_write} !== 4'b0000) begin errors++; $display("FAIL b2b_gate_ctrl got %b exp 0000", {ex_valid, ex_wb_en, ex_mem_read, ex_mem_write}); end
        checks++; if ({ex_src1, ex_dest, ex_val1} !== {3'd5, 3'd7, 16'h2222}) begin errors++; $display("FAIL b2b_gate_fields got %0h %0h %0h exp 5 7 2222", ex_src1, ex_dest, ex_val1); end
    endtask

    task automatic test_load_use_fwd();
        do_reset();
        forwarding_en = 1'b1;
        // lw r3, 4(r1)
        drive_id(1'b1, 3'd1, 3'd0, 3'd3, 1'b0, 16'h0010, 16'h0000, 16'h0004, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checks++; if ({ex_valid, ex_mem_read, ex_dest} !== {1'b1, 1'b1, 3'd3}) begin errors++; $display("FAIL lu_lw_in_ex got %0h %0h %0h exp 1 1 3", ex_valid, ex_mem_read, ex_dest); end
        // add r4, r3, r1
        drive_id(1'b1, 3'd3, 3'd1, 3'd4, 1'b1, 16'h1111, 16'h2222, 16'h0000, 4'h1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0h exp 1", hazard_stall); end
        tick();
        checks++; if ({ex_valid, ex_wb_en, ex_mem_read, ex_src1, ex_dest} !== {1'b0, 1'b0, 1'b0, 3'd0, 3'd0}) begin errors++; $display("FAIL lu_bubble got %0h %0h %0h %0h %0h", ex_valid, ex_wb_en, ex_mem_read, ex_src1, ex_dest); end
        checks++; if (ex_val1 !== 16'h0010) begin errors++; $display("FAIL lu_bubble_hold got %0h exp 0010", ex_val1); end
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count1 got %0d exp 1", stall_count); end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop got %0h exp 0", hazard_stall); end
        tick();
        checks++; if ({ex_valid, ex_src1, ex_src2, ex_dest, ex_val1, ex_alu_cmd} !== {1'b1, 3'd3, 3'd1, 3'd4, 16'h1111, 4'h1}) begin errors++; $display("FAIL lu_enter got %0h %0h %0h %0h %0h %0h", ex_valid, ex_src1, ex_src2, ex_dest, ex_val1, ex_alu_cmd); end
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count_final got %0d exp 1", stall_count); end
    endtask

    task automatic test_nofwd_two_bubbles();
        do_reset();
        forwarding_en = 1'b0;
        // addi r2, r0, 5
        drive_id(1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 16'h0000, 16'h0000, 16'h0005, 4'h0, 1'b1, 1'b0, 1'b0);
        tick();
        // add r5, r2, r6
        drive_id(1'b1, 3'd2, 3'd6, 3'd5, 1'b1, 16'h0A0A, 16'h0B0B, 16'h0000, 4'h1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL nf_stall_ex got %0h exp 1", hazard_stall); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL nf_bubble1 got %0h exp 0", ex_valid); end
        mem_dest = 3'd2; mem_wb_en = 1'b1;
        #1;
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL nf_stall_mem got %0h exp 1", hazard_stall); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL nf_bubble2 got %0h exp 0", ex_valid); end
        // producer moved to WB: no hazard
        mem_dest = 3'd0; mem_wb_en = 1'b0;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL nf_wb_no_stall got %0h exp 0", hazard_stall); end
        tick();
        checks++; if ({ex_valid, ex_src1, ex_src2, ex_dest} !== {1'b1, 3'd2, 3'd6, 3'd5}) begin errors++; $display("FAIL nf_enter got %0h %0h %0h %0h", ex_valid, ex_src1, ex_src2, ex_dest); end
        checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL nf_count got %0d exp 2", stall_count); end
    endtask

    task automatic test_branch_priority();
        do_reset();
        forwarding_en = 1'b1;
        drive_id(1'b1, 3'd1, 3'd0, 3'd3, 1'b0, 16'h0010, 16'h0000, 16'h0004, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 3'd3, 3'd1, 3'd4, 1'b1, 16'h1111, 16'h2222, 16'h0000, 4'h1, 1'b1, 1'b0, 1'b0);
        branch_taken = 1'b1;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL br_stall_masked got %0h exp 0", hazard_stall); end
        tick();
        checks++; if ({ex_valid, ex_wb_en, ex_dest} !== {1'b0, 1'b0, 3'd0}) begin errors++; $display("FAIL br_bubble got %0h %0h %0h exp 0 0 0", ex_valid, ex_wb_en, ex_dest); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL br_count got %0d exp 0", stall_count); end
        // independent instruction still squashed by a branch
        drive_id(1'b1, 3'd5, 3'd6, 3'd7, 1'b1, 16'h7777, 16'h8888, 16'h0000, 4'h3, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if ({ex_valid, ex_val1} !== {1'b0, 16'h0010}) begin errors++; $display("FAIL br_squash got %0h %0h exp 0 0010", ex_valid, ex_val1); end
        branch_taken = 1'b0;
        tick();
        checks++; if ({ex_valid, ex_dest, ex_val1} !== {1'b1, 3'd7, 16'h7777}) begin errors++; $display("FAIL br_resume got %0h %0h %0h", ex_valid, ex_dest, ex_val1); end
    endtask

    task automatic test_r0_and_src2();
        do_reset();
        forwarding_en = 1'b1;
        // lw r0 (dest 0)
        drive_id(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 16'h4321, 16'h0000, 16'h0000, 4'h2, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL r0_no_stall got %0h exp 0", hazard_stall); end
        tick();
        checks++; if ({ex_valid, ex_dest, ex_val1} !== {1'b1, 3'd4, 16'h4321}) begin errors++; $display("FAIL r0_enter got %0h %0h %0h", ex_valid, ex_dest, ex_val1); end
        // lw r3, then instruction naming r3 only in an unused src2 field
        drive_id(1'b1, 3'd1, 3'd0, 3'd3, 1'b0, 16'h0000, 16'h0000, 16'h0008, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 3'd1, 3'd3, 3'd5, 1'b0, 16'h5555, 16'h0000, 16'h0000, 4'h4, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL s2_unused_no_stall got %0h exp 0", hazard_stall); end
        id_use_src2 = 1'b1;
        #1;
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL s2_used_stall got %0h exp 1", hazard_stall); end
        id_use_src2 = 1'b0;
        tick();
        checks++; if ({ex_valid, ex_dest, stall_count} !== {1'b1, 3'd5, 16'd0}) begin errors++; $display("FAIL s2_enter got %0h %0h %0h", ex_valid, ex_dest, stall_count); end
    endtask

    task automatic test_reset_clears_hazard();
        do_reset();
        forwarding_en = 1'b1;
        drive_id(1'b1, 3'd1, 3'd0, 3'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 3'd3, 3'd0, 3'd4, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'h1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        checks++; if ({hazard_stall, ex_valid, stall_count} !== {1'b0, 1'b0, 16'd0}) begin errors++; $display("FAIL rsthz got %0h %0h %0h exp 0 0 0", hazard_stall, ex_valid, stall_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        forwarding_en = 1'b0;
        mem_dest = 3'd2; mem_wb_en = 1'b1;
        drive_id(1'b1, 3'd2, 3'd0, 3'd1, 1'b0, 16'h9999, 16'h8888, 16'h7777, 4'h6, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        checks++; if (stall_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got %0h exp fffe", stall_count); end
        tick();
        checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got %0h exp ffff", stall_count); end
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL sat_still_stall got %0h exp 1", hazard_stall); end
        tick();
        checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %0h exp ffff", stall_count); end
        // reset in the middle of the stall
        rst_n = 1'b0;
        tick();
        checks++; if ({ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_src1, ex_src2, ex_dest} !== 13'd0) begin errors++; $display("FAIL sat_rst_ctrl got %0h %0h %0h %0h %0h %0h %0h", ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_src1, ex_src2, ex_dest); end
        checks++; if ({ex_val1, ex_val2, ex_imm, ex_alu_cmd} !== 52'd0) begin errors++; $display("FAIL sat_rst_data got %0h %0h %0h %0h", ex_val1, ex_val2, ex_imm, ex_alu_cmd); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL sat_rst_count got %0h exp 0", stall_count); end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_load_use_fwd();
        test_nofwd_two_bubbles();
        test_branch_priority();
        test_r0_and_src2();
        test_reset_clears_hazard();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
